// File: rtl/pc_sequencer_if.sv
// Bus between the picoMIPS decoder and the program-counter stage.
// Carries the decoder controls, the continue button and the ROM address.
interface pc_sequencer_if #(
    parameter int PSIZE = 6
);
    logic             PCincr;
    logic             PCabsbranch;
    logic             show;
    logic [PSIZE-1:0] branch_addr;
    logic             cont_btn;
    logic [PSIZE-1:0] PCout;
    logic             show_wait;

    modport master (
        output PCincr, PCabsbranch, show, branch_addr, cont_btn,
        input  PCout, show_wait
    );

    modport slave (
        input  PCincr, PCabsbranch, show, branch_addr, cont_btn,
        output PCout, show_wait
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program counter for picoMIPS with SHOW pause; the pause is released by a
// synchronised, edge-detected continue button.
module pc_sequencer #(
    parameter int PSIZE     = 6,
    parameter int BOOT_ADDR = 0
) (
    input logic           clk,
    input logic           reset,
    pc_sequencer_if.slave bus
);
    localparam logic [PSIZE-1:0] BOOT = PSIZE'(BOOT_ADDR);

    typedef enum logic {RUN, HOLD} state_t;

    state_t           state;
    logic [PSIZE-1:0] pc;
    logic             wait_q;
    logic             sync1;
    logic             sync2;
    logic             prev;
    logic             press;

    // One pulse per rising edge of the synchronised button level.
    assign press = sync2 & ~prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= RUN;
            pc     <= BOOT;
            wait_q <= 1'b0;
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            prev   <= 1'b0;
        end else begin
            sync1 <= bus.cont_btn;
            sync2 <= sync1;
            prev  <= sync2;
            case (state)
                RUN: begin
                    if (bus.PCabsbranch) begin
                        pc <= bus.branch_addr;
                    end else if (bus.PCincr) begin
                        pc <= pc + 1'b1;
                    end else if (bus.show) begin
                        state  <= HOLD;
                        wait_q <= 1'b1;
                    end
                end
                HOLD: begin
                    // Presses seen while still in RUN never reach here.
                    if (press) begin
                        pc     <= pc + 1'b1;
                        state  <= RUN;
                        wait_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= RUN;
                    wait_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.PCout     = pc;
    assign bus.show_wait = wait_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: reset, wrap, branch priority, SHOW pause,
// stale press, reset during HOLD and stall.
module tb_pc_sequencer;
    localparam int PSIZE = 6;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    pc_sequencer_if #(.PSIZE(PSIZE)) bus ();

    pc_sequencer #(
        .PSIZE    (PSIZE),
        .BOOT_ADDR(0)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ctl(input logic incr, input logic br, input logic sh, input int unsigned ba);
        bus.PCincr      = incr;
        bus.PCabsbranch = br;
        bus.show        = sh;
        bus.branch_addr = PSIZE'(ba);
    endtask

    task automatic expect_state(input string tag, input int unsigned pc, input int unsigned sw);
        check({tag, "_pc"}, bus.PCout, pc);
        check({tag, "_sw"}, bus.show_wait, sw);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        bus.cont_btn = 1'b1;
        ctl(0, 0, 0, 0);

        // Reset with the button held
        tick();
        tick();
        expect_state("reset", 0, 0);
        reset = 1'b0;
        ctl(1, 0, 0, 0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            expect_state("inc_after_reset", i, 0);
        end
        bus.cont_btn = 1'b0;

        // Wrap and branch priority
        ctl(0, 1, 0, 62);
        tick();
        expect_state("branch62", 62, 0);
        ctl(1, 0, 0, 0);
        tick();
        expect_state("inc63", 63, 0);
        tick();
        expect_state("wrap0", 0, 0);
        ctl(1, 1, 1, 'h2A);
        tick();
        expect_state("branch_wins", 'h2A, 0);

        // SHOW pause with random decoder noise
        ctl(0, 1, 0, 5);
        tick();
        ctl(0, 0, 1, 0);
        tick();
        expect_state("show_enter", 5, 1);
        for (int i = 0; i < 20; i++) begin
            ctl(1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 63));
            tick();
            expect_state("hold_noise", 5, 1);
        end
        ctl(0, 0, 0, 0);
        bus.cont_btn = 1'b1;
        tick();
        expect_state("btn_e1", 5, 1);
        tick();
        expect_state("btn_e2", 5, 1);
        tick();
        expect_state("btn_e3", 6, 0);
        tick();
        bus.cont_btn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_state("after_release", 6, 0);
        end

        // Stale press coincident with HOLD entry is discarded
        bus.cont_btn = 1'b1;
        tick();
        tick();
        ctl(0, 0, 1, 0);
        tick();
        expect_state("stale_enter", 6, 1);
        ctl(0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            expect_state("stale_hold", 6, 1);
        end
        bus.cont_btn = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        expect_state("stale_still", 6, 1);
        bus.cont_btn = 1'b1;
        tick();
        tick();
        expect_state("repress_e2", 6, 1);
        tick();
        expect_state("repress_exit", 7, 0);
        bus.cont_btn = 1'b0;
        for (int i = 0; i < 3; i++) tick();

        // Reset during HOLD
        ctl(0, 1, 0, 9);
        tick();
        ctl(0, 0, 1, 0);
        tick();
        expect_state("hold9", 9, 1);
        ctl(0, 0, 0, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        expect_state("reset_in_hold", 0, 0);
        ctl(1, 0, 0, 0);
        tick();
        expect_state("post_reset_inc1", 1, 0);
        tick();
        expect_state("post_reset_inc2", 2, 0);

        // Stall
        ctl(0, 1, 0, 17);
        tick();
        ctl(0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            expect_state("stall", 17, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter stage directly upstream of the picoMIPS instruction decoder.
- Consumes the decoder's PCincr, PCabsbranch and show controls plus the branch target, and produces the program address for the instruction ROM. The ROM's top 4 bits return to the decoder as opcode.
- Implements the SHOW pause: the PC freezes until the operator presses an asynchronous continue button, which is synchronised and edge-detected here.

Parameters:
- PSIZE, 6, program address width in bits.
- BOOT_ADDR, 0, PC value after reset. Must fit in PSIZE bits.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- PCincr  input  1  decoder: advance PC by 1.
- PCabsbranch  input  1  decoder: load branch_addr.
- show  input  1  decoder: SHOW instruction, pause requested.
- branch_addr  input  PSIZE  absolute branch target (immediate field).
- cont_btn  input  1  continue push-button, asynchronous to clk, active-high.
- PCout  output  PSIZE  current program address to instruction ROM.
- show_wait  output  1  high while paused in HOLD.

Behaviour:
- Reset is the only reset; it is synchronous and active-high. While reset is high at a clk edge:
  - PCout=BOOT_ADDR; state=RUN; show_wait=0.
  - Both synchroniser flops and the edge-history flop are cleared to 0.
- Reset asserted while in HOLD returns to RUN immediately; no button press is needed afterwards.
- Button conditioning:
  - cont_btn passes through two flops (sync1, sync2), then one history flop (prev).
  - press = sync2 & ~prev, a one-cycle pulse per rising edge.
  - A level held high produces exactly one pulse.
- FSM states: RUN, HOLD. show_wait = (state==HOLD), registered, no combinational path from inputs.
- RUN, evaluated each edge, priority high to low:
  1. PCabsbranch=1: PC <= branch_addr. Other inputs are ignored.
  2. PCincr=1: PC <= PC+1, modulo 2^PSIZE (all-ones wraps to 0).
  3. show=1: PC unchanged; state <= HOLD.
  4. Otherwise: PC unchanged (stall).
- HOLD:
  - PCincr, PCabsbranch, show and branch_addr are ignored; PC is held.
  - When press=1: PC <= PC+1 (wrapping) and state <= RUN.
  - press pulses that occur while in RUN are discarded, including one coincident with the edge that enters HOLD. Only a press generated while state==HOLD releases the pause.
- Latency:
  - Branch or increment: PCout updates on the clk edge where the control is sampled (1 cycle).
  - Button: cont_btn rising before edge N gives sync1=1 after N, sync2=1 after N+1, press high during cycle N+1..N+2, and PC+1 with show_wait=0 after edge N+2.
- Width rules: the PC adder is PSIZE bits and the carry out is dropped. branch_addr is used unmodified, with no sign extension or offset.
- Simultaneous show and PCabsbranch/PCincr (not generated by the decoder) resolve by the priority above; no HOLD entry.

Test Plan:
- Reset: reset=1 for 2 cycles with cont_btn=1 held → PCout=0 and show_wait=0. After release, with PCincr=1 for 3 cycles → PCout 1,2,3. The held button never causes a HOLD exit.
- Wrap and branch (PSIZE=6): from PC=62 with PCincr=1 → 63, then 0. Then PCabsbranch=1, PCincr=1, branch_addr=0x2A → PCout=0x2A next cycle (branch wins).
- SHOW pause: at PC=5, PCincr=0 and show=1 → show_wait=1 next cycle and PCout stays 5 for 20 cycles while inputs toggle randomly. Pulse cont_btn high 4 cycles → exactly 3 edges after the rise, PCout=6 and show_wait=0; PC does not advance further from that press.
- Stale press: cont_btn rises 2 cycles before show is sampled, so press fires while still in RUN → stays in HOLD at the same PC. Only a later release-and-press exits.
- Reset mid-HOLD: in HOLD at PC=9, assert reset one cycle → PCout=0, show_wait=0. Subsequent PCincr advances normally.
- Stall: PCincr=0, PCabsbranch=0, show=0 for 5 cycles at PC=17 → PCout stays 17 and show_wait stays 0.
